// File: rtl/rice_core_fetch_stage.sv
// IF stage: in-order imem requests, FIFO_DEPTH-entry instruction buffer, flush discards stale responses; response->o_if_valid 1 cycle.
// Backpressure: i_id_ready low holds the head and requests stop at outstanding+occupancy==FIFO_DEPTH; RICE_CORE_FETCH_BYPASS_EN adds a 0-cycle bypass.
module rice_core_fetch_stage #(
    parameter int unsigned XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    output logic            o_inst_request_valid,
    input  logic            i_inst_request_ack,
    output logic [XLEN-1:0] o_inst_request_address,
    output logic            o_inst_request_issued,
    input  logic            i_inst_response_valid,
    input  logic [31:0]     i_inst_response_data,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_if_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d, fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [AW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [XLEN-1:0] pcq_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] pcq_mem_d [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_d [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [31:0]     fifo_inst_d [FIFO_DEPTH];

    logic [CW:0] inflight;
    logic        issue, resp_keep, resp_drop, fifo_empty;
    logic        bypass, bypass_take, fifo_push, fifo_pop;

    // Every request in flight or buffered owns a FIFO slot, so the FIFO can never overflow.
    assign inflight   = {1'b0, out_q} + {1'b0, fifo_cnt_q};
    assign o_inst_request_valid   = i_enable && !i_flush && (inflight < (CW+1)'(FIFO_DEPTH));
    assign issue                  = o_inst_request_valid && i_inst_request_ack;
    assign o_inst_request_issued  = issue;
    assign o_inst_request_address = pc_q;
    assign resp_keep  = i_inst_response_valid && (drop_q == '0);
    assign resp_drop  = i_inst_response_valid && (drop_q != '0);
    assign fifo_empty = (fifo_cnt_q == '0);

`ifdef RICE_CORE_FETCH_BYPASS_EN
    assign bypass      = resp_keep && fifo_empty && !i_flush;
    assign bypass_take = bypass && i_id_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign fifo_push = resp_keep && !bypass_take;
    assign fifo_pop  = !fifo_empty && i_id_ready;

    always_comb begin
        o_if_valid = !fifo_empty || bypass;
        o_if_pc    = fifo_pc_q[fifo_rd_q];
        o_if_inst  = fifo_inst_q[fifo_rd_q];
        if (bypass) begin
            o_if_pc   = pcq_mem_q[pcq_rd_q];
            o_if_inst = i_inst_response_data;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        out_d       = out_q;
        drop_d      = drop_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;
        pcq_mem_d   = pcq_mem_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        if (i_flush) begin
            // Whatever is still in flight after this cycle's response belongs to the old path.
            pc_d       = {i_flush_pc[XLEN-1:2], 2'b00};
            out_d      = out_q - CW'(i_inst_response_valid);
            drop_d     = out_q - CW'(i_inst_response_valid);
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (issue) begin
                pc_d                = pc_q + XLEN'(4);
                pcq_mem_d[pcq_wr_q] = pc_q;
                pcq_wr_d            = pcq_wr_q + AW'(1);
            end
            out_d = out_q + CW'(issue) - CW'(i_inst_response_valid);
            if (resp_drop) drop_d = drop_q - CW'(1);
            if (resp_keep) pcq_rd_d = pcq_rd_q + AW'(1);
            if (fifo_push) begin
                fifo_pc_d[fifo_wr_q]   = pcq_mem_q[pcq_rd_q];
                fifo_inst_d[fifo_wr_q] = i_inst_response_data;
                fifo_wr_d              = fifo_wr_q + AW'(1);
            end
            if (fifo_pop) fifo_rd_d = fifo_rd_q + AW'(1);
            fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= RESET_PC;
            out_q       <= '0;
            drop_q      <= '0;
            pcq_wr_q    <= '0;
            pcq_rd_q    <= '0;
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
            pcq_mem_q   <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            fifo_inst_q <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            pcq_wr_q    <= pcq_wr_d;
            pcq_rd_q    <= pcq_rd_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            pcq_mem_q   <= pcq_mem_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
        end
    end

    a_resp_has_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_inst_response_valid |-> (out_q != '0));

endmodule

// File: tb/tb_rice_core_fetch_stage.sv
// Bench for rice_core_fetch_stage: directed cycle table, multi-cycle corner sequences and a randomized run against a queue model.
module tb_rice_core_fetch_stage;
    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, ack = 1'b0, rsp = 1'b0, fl = 1'b0, rdy = 1'b0;
    logic [31:0] rdata = '0;
    logic [63:0] fpc = '0;
    logic        rv, iss, ifv;
    logic [63:0] addr, ifpc;
    logic [31:0] ifinst;

    logic        w_en = 1'b0;
    logic        w_rv, w_iss, w_ifv;
    logic [63:0] w_addr, w_ifpc;
    logic [31:0] w_ifinst;

    always #5 clk = ~clk;

    rice_core_fetch_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .o_inst_request_valid(rv), .i_inst_request_ack(ack),
        .o_inst_request_address(addr), .o_inst_request_issued(iss),
        .i_inst_response_valid(rsp), .i_inst_response_data(rdata),
        .i_flush(fl), .i_flush_pc(fpc),
        .o_if_valid(ifv), .i_id_ready(rdy), .o_if_pc(ifpc), .o_if_inst(ifinst)
    );

    rice_core_fetch_stage #(.RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(w_en),
        .o_inst_request_valid(w_rv), .i_inst_request_ack(1'b1),
        .o_inst_request_address(w_addr), .o_inst_request_issued(w_iss),
        .i_inst_response_valid(1'b0), .i_inst_response_data(32'h0),
        .i_flush(1'b0), .i_flush_pc(64'h0),
        .o_if_valid(w_ifv), .i_id_ready(1'b1), .o_if_pc(w_ifpc), .o_if_inst(w_ifinst)
    );

    typedef struct {
        logic        en, ack, rsp;
        logic [63:0] rsp_pc;
        logic        fl;
        logic [63:0] fpc;
        logic        rdy;
        logic        rv;
        logic [63:0] addr;
        logic        iss, ifv;
        logic [63:0] ifpc;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state for the randomized run
    logic [63:0] m_pc;
    int          m_out, m_stale;
    logic [63:0] live_q[$];
    logic [63:0] mem_q[$];
    logic [63:0] fq_pc[$];
    logic [31:0] fq_inst[$];

    function automatic logic [31:0] memword(logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t v(bit e, bit a, bit r, int roff, bit f, logic [63:0] fp, bit rd,
                               bit erv, int aoff, bit eiss, bit eifv, int ioff);
        vec_t t;
        t.en = e; t.ack = a; t.rsp = r; t.rsp_pc = B + 64'(roff);
        t.fl = f; t.fpc = fp; t.rdy = rd;
        t.rv = erv; t.addr = B + 64'(aoff); t.iss = eiss; t.ifv = eifv; t.ifpc = B + 64'(ioff);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en = 0; ack = 0; rsp = 0; fl = 0; rdy = 0; rdata = '0; fpc = '0; w_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " rst req_valid"}, rv, 1'b0);
        chk({tag, " rst issued"}, iss, 1'b0);
        chk({tag, " rst if_valid"}, ifv, 1'b0);
        chk({tag, " rst address"}, addr, B);
        chk({tag, " rst if_pc"}, ifpc, 64'h0);
        chk({tag, " rst if_inst"}, ifinst, 64'h0);
        chk({tag, " rst wrap address"}, w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        rst_n = 1'b1;
    endtask

    initial begin
        // Directed cycle table starting from reset (1-cycle buffered latency, FIFO_DEPTH = 2)
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h00,1, 0,0));
        vt.push_back(v(1,1,1,'h00, 0,0,1, 1,'h04,1, 0,0));
        vt.push_back(v(1,1,1,'h04, 0,0,1, 0,'h08,0, 1,'h00));
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h08,1, 1,'h04));
        vt.push_back(v(1,1,1,'h08, 0,0,1, 1,'h0C,1, 0,0));
        vt.push_back(v(1,0,0,0,    0,0,1, 0,'h10,0, 1,'h08));
        vt.push_back(v(1,0,1,'h0C, 0,0,1, 1,'h10,0, 0,0));
        vt.push_back(v(1,0,0,0,    0,0,0, 1,'h10,0, 1,'h0C));
        vt.push_back(v(1,0,0,0,    0,0,0, 1,'h10,0, 1,'h0C));
        vt.push_back(v(1,1,0,0,    0,0,0, 1,'h10,1, 1,'h0C));
        vt.push_back(v(1,1,1,'h10, 0,0,0, 0,'h14,0, 1,'h0C));
        vt.push_back(v(1,1,0,0,    0,0,0, 0,'h14,0, 1,'h0C));
        vt.push_back(v(1,1,0,0,    0,0,1, 0,'h14,0, 1,'h0C));
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h14,1, 1,'h10));
        vt.push_back(v(1,1,1,'h14, 0,0,1, 1,'h18,1, 0,0));
        vt.push_back(v(1,1,0,0,    0,0,1, 0,'h1C,0, 1,'h14));
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h1C,1, 0,0));
        // Flush with two requests outstanding: both stale responses vanish
        vt.push_back(v(1,1,0,0,    1,B+64'h102,1, 0,'h20,0, 0,0));
        vt.push_back(v(1,1,1,'h18, 0,0,1, 0,'h100,0, 0,0));
        vt.push_back(v(1,1,1,'h1C, 0,0,1, 1,'h100,1, 0,0));
        vt.push_back(v(1,0,1,'h100,0,0,1, 1,'h104,0, 0,0));
        vt.push_back(v(1,0,0,0,    0,0,1, 1,'h104,0, 1,'h100));
        // Flush coinciding with a response and a pending request
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h104,1, 0,0));
        vt.push_back(v(1,1,0,0,    0,0,1, 1,'h108,1, 0,0));
        vt.push_back(v(1,1,1,'h104,1,B+64'h200,1, 0,'h10C,0, 0,0));
        vt.push_back(v(1,1,1,'h108,0,0,1, 1,'h200,1, 0,0));
        vt.push_back(v(1,0,1,'h200,0,0,1, 1,'h204,0, 0,0));
        vt.push_back(v(1,0,0,0,    0,0,1, 1,'h204,0, 1,'h200));

        do_reset("first");

        // PC wrap: second request after 0xFFFF_FFFF_FFFF_FFFC is 0x0
        w_en = 1'b1;
        #1;
        chk("wrap first valid", w_rv, 1'b1);
        chk("wrap first address", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap first issued", w_iss, 1'b1);
        tick();
        chk("wrap second address", w_addr, 64'h0);
        w_en = 1'b0;

`ifndef RICE_CORE_FETCH_BYPASS_EN
        for (int i = 0; i < vt.size(); i++) begin
            en = vt[i].en; ack = vt[i].ack; rsp = vt[i].rsp; fl = vt[i].fl;
            fpc = vt[i].fpc; rdy = vt[i].rdy;
            rdata = vt[i].rsp ? memword(vt[i].rsp_pc) : 32'hDEAD_BEEF;
            #1;
            chk($sformatf("row%0d req_valid", i), rv, vt[i].rv);
            chk($sformatf("row%0d address", i), addr, vt[i].addr);
            chk($sformatf("row%0d issued", i), iss, vt[i].iss);
            chk($sformatf("row%0d if_valid", i), ifv, vt[i].ifv);
            if (vt[i].ifv) begin
                chk($sformatf("row%0d if_pc", i), ifpc, vt[i].ifpc);
                chk($sformatf("row%0d if_inst", i), ifinst, memword(vt[i].ifpc));
            end
            @(posedge clk);
            #1;
        end
`endif

        // Randomized run against a queue-level model
        do_reset("second");
        m_pc = B; m_out = 0; m_stale = 0;
        live_q.delete(); mem_q.delete(); fq_pc.delete(); fq_inst.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        e_rv, e_ifv, keep, byp;
            logic [63:0] h_pc;
            logic [31:0] h_inst;
            en  = ($urandom % 8) != 0;
            ack = ($urandom % 3) != 0;
            rdy = ($urandom % 4) != 0;
            fl  = ($urandom % 24) == 0;
            fpc = {$urandom, $urandom};
            rsp = (mem_q.size() > 0) && ($urandom % 2 == 1);
            rdata = rsp ? memword(mem_q[0]) : $urandom;
            #1;
            e_rv = en && !fl && (m_out + fq_pc.size() < 2);
            keep = rsp && (m_stale == 0);
            byp  = 1'b0;
`ifdef RICE_CORE_FETCH_BYPASS_EN
            byp  = keep && (fq_pc.size() == 0) && !fl;
`endif
            e_ifv = (fq_pc.size() > 0) || byp;
            h_pc = '0; h_inst = '0;
            if (fq_pc.size() > 0) begin
                h_pc = fq_pc[0]; h_inst = fq_inst[0];
            end else if (byp) begin
                h_pc = live_q[0]; h_inst = rdata;
            end
            chk($sformatf("rnd%0d req_valid", c), rv, e_rv);
            chk($sformatf("rnd%0d address", c), addr, m_pc);
            chk($sformatf("rnd%0d issued", c), iss, e_rv && ack);
            chk($sformatf("rnd%0d if_valid", c), ifv, e_ifv);
            if (e_ifv) begin
                chk($sformatf("rnd%0d if_pc", c), ifpc, h_pc);
                chk($sformatf("rnd%0d if_inst", c), ifinst, h_inst);
            end
            if (fl) begin
                if (rsp) void'(mem_q.pop_front());
                m_out   = m_out - int'(rsp);
                m_stale = m_out;
                live_q.delete(); fq_pc.delete(); fq_inst.delete();
                m_pc = {fpc[63:2], 2'b00};
            end else begin
                if (fq_pc.size() > 0 && rdy) begin
                    void'(fq_pc.pop_front());
                    void'(fq_inst.pop_front());
                end
                if (rsp) begin
                    void'(mem_q.pop_front());
                    m_out--;
                    if (m_stale > 0) m_stale--;
                    else begin
                        h_pc = live_q.pop_front();
                        if (!(byp && rdy)) begin
                            fq_pc.push_back(h_pc);
                            fq_inst.push_back(rdata);
                        end
                    end
                end
                if (e_rv && ack) begin
                    live_q.push_back(m_pc);
                    mem_q.push_back(m_pc);
                    m_pc = m_pc + 64'd4;
                    m_out++;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
